// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational reads, writes/trap/mret commit on the next rising edge.
// Always ready (no backpressure); irq_pending is registered one cycle behind mip/mie/mstatus.MIE.
module csr_regfile #(
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic        csr_rd_illegal,
   input  logic        csr_wen,
   input  logic [11:0] csr_waddr,
   input  logic [31:0] csr_wdata,
   input  logic        instr_retire,
   input  logic        trap_en,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret_en,
   input  logic        ext_irq,
   input  logic        timer_irq,
   input  logic        sw_irq,
   output logic [31:0] trap_vector,
   output logic [31:0] mepc_out,
   output logic        irq_pending
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTR   = 12'hB02;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_MHARTID  = 12'hF14;
   localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

   logic        st_mie;
   logic        st_mpie;
   logic [31:0] mie_r;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [31:0] mstatus;
   logic [31:0] mip;
   logic [31:0] tvec_base;
   logic        wr_ok;

   assign mstatus   = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
   assign mip       = {20'd0, ext_irq, 3'd0, timer_irq, 3'd0, sw_irq, 3'd0};
   assign mepc_out  = mepc;
   // csr_wen only commits when neither trap nor mret claims the edge
   assign wr_ok     = csr_wen & ~trap_en & ~mret_en;
   assign tvec_base = {mtvec[31:2], 2'b00};

   always_comb begin
      trap_vector = tvec_base;
      if (mtvec[1:0] == 2'b01 && trap_cause[31])
         trap_vector = tvec_base + {trap_cause[29:0], 2'b00};
   end

   always_comb begin
      csr_rdata      = 32'd0;
      csr_rd_illegal = 1'b0;
      case (csr_raddr)
         A_MSTATUS:  csr_rdata = mstatus;
         A_MISA:     csr_rdata = MISA_VAL;
         A_MIE:      csr_rdata = mie_r;
         A_MTVEC:    csr_rdata = mtvec;
         A_MSCRATCH: csr_rdata = mscratch;
         A_MEPC:     csr_rdata = mepc;
         A_MCAUSE:   csr_rdata = mcause;
         A_MTVAL:    csr_rdata = mtval;
         A_MIP:      csr_rdata = mip;
         A_MCYCLE:   csr_rdata = mcycle[31:0];
         A_MCYCLEH:  csr_rdata = mcycle[63:32];
         A_MINSTR:   csr_rdata = minstret[31:0];
         A_MINSTRH:  csr_rdata = minstret[63:32];
         A_MHARTID:  csr_rdata = HART_ID;
         default:    csr_rd_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_mie      <= 1'b0;
         st_mpie     <= 1'b0;
         mie_r       <= 32'd0;
         mtvec       <= MTVEC_RESET;
         mscratch    <= 32'd0;
         mepc        <= 32'd0;
         mcause      <= 32'd0;
         mtval       <= 32'd0;
         mcycle      <= 64'd0;
         minstret    <= 64'd0;
         irq_pending <= 1'b0;
      end else begin
         irq_pending <= st_mie & (|(mip & mie_r));

         // a counter write replaces the increment for that cycle, no carry across halves
         if (wr_ok && csr_waddr == A_MCYCLE)
            mcycle[31:0] <= csr_wdata;
         else if (wr_ok && csr_waddr == A_MCYCLEH)
            mcycle[63:32] <= csr_wdata;
         else
            mcycle <= mcycle + 64'd1;

         if (wr_ok && csr_waddr == A_MINSTR)
            minstret[31:0] <= csr_wdata;
         else if (wr_ok && csr_waddr == A_MINSTRH)
            minstret[63:32] <= csr_wdata;
         else if (instr_retire)
            minstret <= minstret + 64'd1;

         if (trap_en) begin
            mepc    <= trap_pc & ~32'd3;
            mcause  <= trap_cause;
            mtval   <= trap_tval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
         end else if (mret_en) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end else if (csr_wen) begin
            case (csr_waddr)
               A_MSTATUS: begin
                  st_mie  <= csr_wdata[3];
                  st_mpie <= csr_wdata[7];
               end
               A_MIE:      mie_r    <= csr_wdata & MIE_MASK;
               A_MTVEC:    mtvec    <= csr_wdata & ~32'd2;
               A_MSCRATCH: mscratch <= csr_wdata;
               A_MEPC:     mepc     <= csr_wdata & ~32'd3;
               A_MCAUSE:   mcause   <= csr_wdata;
               A_MTVAL:    mtval    <= csr_wdata;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile with hand-computed expected values.
module tb_csr_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] csr_raddr = 12'h0;
   logic [31:0] csr_rdata;
   logic        csr_rd_illegal;
   logic        csr_wen = 1'b0;
   logic [11:0] csr_waddr = 12'h0;
   logic [31:0] csr_wdata = 32'h0;
   logic        instr_retire = 1'b0;
   logic        trap_en = 1'b0;
   logic [31:0] trap_pc = 32'h0;
   logic [31:0] trap_cause = 32'h0;
   logic [31:0] trap_tval = 32'h0;
   logic        mret_en = 1'b0;
   logic        ext_irq = 1'b0;
   logic        timer_irq = 1'b0;
   logic        sw_irq = 1'b0;
   logic [31:0] trap_vector;
   logic [31:0] mepc_out;
   logic        irq_pending;

   int n_chk  = 0;
   int n_pass = 0;

   csr_regfile #(
      .HART_ID    (32'd5),
      .MTVEC_RESET(32'h0000_0100),
      .MISA_VAL   (32'h4000_0100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .csr_raddr     (csr_raddr),
      .csr_rdata     (csr_rdata),
      .csr_rd_illegal(csr_rd_illegal),
      .csr_wen       (csr_wen),
      .csr_waddr     (csr_waddr),
      .csr_wdata     (csr_wdata),
      .instr_retire  (instr_retire),
      .trap_en       (trap_en),
      .trap_pc       (trap_pc),
      .trap_cause    (trap_cause),
      .trap_tval     (trap_tval),
      .mret_en       (mret_en),
      .ext_irq       (ext_irq),
      .timer_irq     (timer_irq),
      .sw_irq        (sw_irq),
      .trap_vector   (trap_vector),
      .mepc_out      (mepc_out),
      .irq_pending   (irq_pending)
   );

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_raddr = addr;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      csr_wen   = 1'b1;
      csr_waddr = addr;
      csr_wdata = data;
      step();
      csr_wen   = 1'b0;
   endtask

   initial begin
      #5 rst = 1'b0;
      #10;
      rd("rst_mtvec", 12'h305, 32'h0000_0100);
      rd("rst_mstatus", 12'h300, 32'h0000_1800);
      rd("rst_mcycle", 12'hB00, 32'h0);
      check("rst_irq", {31'd0, irq_pending}, 32'd0);

      step();
      rst = 1'b1;
      rd("hartid", 12'hF14, 32'd5);
      check("hartid_legal", {31'd0, csr_rd_illegal}, 32'd0);
      rd("unmapped", 12'h7C0, 32'h0);
      check("unmapped_illegal", {31'd0, csr_rd_illegal}, 32'd1);
      rd("misa", 12'h301, 32'h4000_0100);
      rd("mcycle_start", 12'hB00, 32'd0);
      step();
      rd("mcycle_one", 12'hB00, 32'd1);
      rd("minstret_zero", 12'hB02, 32'd0);

      // write not visible until after the edge
      csr_wen = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
      rd("no_bypass", 12'h340, 32'h0);
      step();
      csr_wen = 1'b0;
      rd("mscratch", 12'h340, 32'hDEAD_BEEF);

      wr(12'h344, 32'hFFFF_FFFF);
      rd("mip_ro", 12'h344, 32'h0);
      ext_irq = 1'b1;
      rd("mip_ext", 12'h344, 32'h0000_0800);
      ext_irq = 1'b0; sw_irq = 1'b1;
      rd("mip_sw", 12'h344, 32'h0000_0008);
      sw_irq = 1'b0;
      wr(12'hF14, 32'h1234);
      rd("hartid_ro", 12'hF14, 32'd5);

      wr(12'hB00, 32'hFFFF_FFFF);
      rd("mcycle_lo_wr", 12'hB00, 32'hFFFF_FFFF);
      rd("mcycle_hi_pre", 12'hB80, 32'h0);
      step();
      rd("mcycle_lo_wrap", 12'hB00, 32'h0);
      rd("mcycle_hi_inc", 12'hB80, 32'h1);

      instr_retire = 1'b1;
      step(); step(); step();
      instr_retire = 1'b0;
      rd("minstret_3", 12'hB02, 32'd3);
      wr(12'hB82, 32'hA5);
      rd("minstret_hi_wr", 12'hB82, 32'hA5);
      rd("minstret_lo_hold", 12'hB02, 32'd3);

      wr(12'h300, 32'hFFFF_FFFF);
      rd("mstatus_mask", 12'h300, 32'h0000_1888);
      wr(12'h304, 32'hFFFF_FFFF);
      rd("mie_mask", 12'h304, 32'h0000_0888);
      wr(12'h304, 32'h0000_0080);
      timer_irq = 1'b1;
      #1;
      check("irq_not_yet", {31'd0, irq_pending}, 32'd0);
      step();
      check("irq_set", {31'd0, irq_pending}, 32'd1);

      // trap with a competing mepc write on the same edge
      check("tvec_direct", trap_vector, 32'h0000_0100);
      trap_en = 1'b1; trap_pc = 32'h0000_2003; trap_cause = 32'h8000_0007; trap_tval = 32'h55;
      csr_wen = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h0000_1234;
      step();
      trap_en = 1'b0; csr_wen = 1'b0;
      rd("trap_mepc", 12'h341, 32'h0000_2000);
      check("mepc_out", mepc_out, 32'h0000_2000);
      rd("trap_mcause", 12'h342, 32'h8000_0007);
      rd("trap_mtval", 12'h343, 32'h0000_0055);
      rd("trap_mstatus", 12'h300, 32'h0000_1880);
      check("irq_lag", {31'd0, irq_pending}, 32'd1);
      step();
      check("irq_drop", {31'd0, irq_pending}, 32'd0);

      mret_en = 1'b1;
      csr_wen = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h1111;
      step();
      mret_en = 1'b0; csr_wen = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h0000_1888);
      rd("mret_drop_wr", 12'h340, 32'hDEAD_BEEF);
      step();
      check("irq_again", {31'd0, irq_pending}, 32'd1);

      wr(12'h305, 32'h0000_1003);
      rd("mtvec_bit1", 12'h305, 32'h0000_1001);
      trap_cause = 32'h8000_0007;
      #1;
      check("tvec_vectored", trap_vector, 32'h0000_101C);
      trap_cause = 32'h0000_0002;
      #1;
      check("tvec_exc", trap_vector, 32'h0000_1000);
      wr(12'h341, 32'hFFFF_FFFF);
      rd("mepc_align", 12'h341, 32'hFFFF_FFFC);

      rst = 1'b0;
      rd("midrst_mscratch", 12'h340, 32'h0);
      rd("midrst_mstatus", 12'h300, 32'h0000_1800);
      rd("midrst_mtvec", 12'h305, 32'h0000_0100);
      rd("midrst_mcycle_hi", 12'hB80, 32'h0);
      check("midrst_irq", {31'd0, irq_pending}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
